// File: rtl/boid_raster_writer.sv
// Per-frame rasteriser: on each frame_start, swaps display RAMs and plots a BOID_SIZE x BOID_SIZE square per boid.
// Optional macro BOID_RASTER_STATS_EN enables the saturating dropped_frames counter.
module boid_raster_writer #(
  parameter int MAX_BOIDS      = 4,
  parameter int BOID_IDX_WIDTH = 2,
  parameter int BOID_SIZE      = 2,
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_start,
  output logic [BOID_IDX_WIDTH-1:0] boid_sel,
  input  logic [9:0]                boid_x,
  input  logic [8:0]                boid_y,
  output logic                      ram_swap,
  output logic                      ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic                      ram_wdata,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                dropped_frames
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_LATCH,
    S_PLOT,
    S_DONE
  } state_t;

  localparam logic [2:0]                LAST_D   = 3'(BOID_SIZE - 1);
  localparam logic [BOID_IDX_WIDTH-1:0] LAST_SEL = BOID_IDX_WIDTH'(MAX_BOIDS - 1);

  state_t                    state_q, state_d;
  logic [BOID_IDX_WIDTH-1:0] sel_q, sel_d;
  logic [10:0]               bx_q, bx_d;
  logic [9:0]                by_q, by_d;
  logic [2:0]                dx_q, dx_d;
  logic [2:0]                dy_q, dy_d;
  logic                      swap_q, swap_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [10:0]               px;
  logic [9:0]                py;

  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [10:0] x, input logic [9:0] y);
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(x);
  endfunction

  function automatic logic on_screen(input logic [10:0] x, input logic [9:0] y);
    return ({1'b0, x} < 12'(VIDEO_WIDTH)) && ({1'b0, y} < 11'(VIDEO_HEIGHT));
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      S_IDLE:  if (frame_start) state_d = S_SWAP;
      S_SWAP:  state_d = S_LATCH;
      S_LATCH: begin
        bx_d    = {1'b0, boid_x};
        by_d    = {1'b0, boid_y};
        dx_d    = '0;
        dy_d    = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        if (dx_q == LAST_D) begin
          dx_d = '0;
          if (dy_q == LAST_D) begin
            dy_d = '0;
            if (sel_q == LAST_SEL) begin
              state_d = S_DONE;
            end else begin
              sel_d   = sel_q + BOID_IDX_WIDTH'(1);
              state_d = S_LATCH;
            end
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end
      S_DONE:  state_d = frame_start ? S_SWAP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SWAP) sel_d = '0;

    // Outputs are registered from the state being entered, so they line up with that state's cycle.
    px     = bx_d + {8'b0, dx_d};
    py     = by_d + {7'b0, dy_d};
    swap_d = (state_d == S_SWAP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    we_d   = 1'b0;
    addr_d = addr_q;
    if (state_d == S_PLOT && on_screen(px, py)) begin
      we_d   = 1'b1;
      addr_d = pixel_addr(px, py);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      swap_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      swap_q  <= swap_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign boid_sel   = sel_q;
  assign ram_swap   = swap_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = 1'b1;
  assign busy       = busy_q;
  assign frame_done = done_q;

`ifdef BOID_RASTER_STATS_EN
  logic [7:0] drop_q, drop_d;
  logic       ignored;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pulse in DONE starts the next pass, so only SWAP/LATCH/PLOT count as drops.
  always_comb begin
    ignored = frame_start && (state_q == S_SWAP || state_q == S_LATCH || state_q == S_PLOT);
    drop_d  = ignored ? sat_inc8(drop_q) : drop_q;
  end

  always_ff @(posedge clock) begin
    if (reset) drop_q <= 8'd0;
    else       drop_q <= drop_d;
  end

  assign dropped_frames = drop_q;
`else
  assign dropped_frames = 8'd0;
`endif

endmodule
